// File: rtl/otter_fetch_stage_if.sv
// Instruction-memory read port of the OTTER fetch stage.
// master: addr/rden out, dout/rdy in; slave: the memory side.
interface otter_fetch_stage_if;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RDEN;
  logic [31:0] IMEM_DOUT;
  logic        IMEM_RDY;

  modport master (
    output IMEM_ADDR,
    output IMEM_RDEN,
    input  IMEM_DOUT,
    input  IMEM_RDY
  );

  modport slave (
    input  IMEM_ADDR,
    input  IMEM_RDEN,
    output IMEM_DOUT,
    output IMEM_RDY
  );
endinterface

// File: rtl/otter_fetch_stage.sv
// OTTER IF stage: PC register, one-outstanding imem fetch, IF/ID reg.
// Ports: CLK/RST, PC_SOURCE + targets, STALL, imem (master), IFID_*.
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  PC_SOURCE,
  input  logic [31:0] JALR_TGT,
  input  logic [31:0] BRANCH_TGT,
  input  logic [31:0] JAL_TGT,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        STALL,
  otter_fetch_stage_if.master imem,
  output logic        IFID_VALID,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_INSTR
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic [31:0] hold_q;

  logic        rdy;
  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;

  logic        issue;
  logic        load_mem;
  logic        load_hold;
  logic        capture;
  logic        bubble;

  assign rdy = imem.IMEM_RDY;

  always_comb begin
    redirect   = 1'b1;
    target_raw = pc_q;
    case (PC_SOURCE)
      3'd1:    target_raw = JALR_TGT;
      3'd2:    target_raw = BRANCH_TGT;
      3'd3:    target_raw = JAL_TGT;
      3'd4:    target_raw = MTVEC;
      3'd5:    target_raw = MEPC;
      default: redirect   = 1'b0;
    endcase
  end

  assign target = {target_raw[31:2], 2'b00};

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (!redirect) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect)
          state_d = rdy ? S_FETCH : S_DRAIN;
        else if (rdy)
          state_d = STALL ? S_HOLD : S_WAIT;
      end
      S_HOLD: begin
        if (redirect)    state_d = S_FETCH;
        else if (!STALL) state_d = S_WAIT;
      end
      S_DRAIN: begin
        if (rdy) state_d = S_FETCH;
      end
    endcase
  end

  // per-state actions; a redirect suppresses all of them
  always_comb begin
    issue     = 1'b0;
    load_mem  = 1'b0;
    load_hold = 1'b0;
    capture   = 1'b0;
    bubble    = 1'b0;
    if (!redirect) begin
      unique case (state_q)
        S_FETCH: begin
          issue  = 1'b1;
          bubble = !STALL;
        end
        S_WAIT: begin
          if (rdy) begin
            if (!STALL) begin
              load_mem = 1'b1;
              issue    = 1'b1;
            end else begin
              capture  = 1'b1;
            end
          end else begin
            bubble = !STALL;
          end
        end
        S_HOLD: begin
          if (!STALL) begin
            load_hold = 1'b1;
            issue     = 1'b1;
          end
        end
        S_DRAIN: begin
          bubble = !STALL;
        end
      endcase
    end
  end

  assign imem.IMEM_RDEN = issue & ~RST;
  assign imem.IMEM_ADDR = pc_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= RESET_VEC;
      req_pc_q   <= 32'h0;
      hold_q     <= NOP_INSTR;
      IFID_VALID <= 1'b0;
      IFID_PC    <= 32'h0;
      IFID_INSTR <= NOP_INSTR;
    end else begin
      if (redirect) begin
        pc_q <= target;
      end else if (issue) begin
        pc_q     <= pc_q + 32'd4;
        req_pc_q <= pc_q;
      end

      if (capture) hold_q <= imem.IMEM_DOUT;

      // load_hold reuses req_pc_q: nothing was issued while holding
      if (redirect) begin
        IFID_VALID <= 1'b0;
      end else if (load_mem || load_hold) begin
        IFID_VALID <= 1'b1;
        IFID_PC    <= req_pc_q;
        IFID_INSTR <= load_mem ? imem.IMEM_DOUT : hold_q;
      end else if (bubble) begin
        IFID_VALID <= 1'b0;
      end
    end
  end

endmodule
